// File: rtl/ex_muldiv_if.sv
// Request/result bundle between the ID/EX stage and the iterative multiply/divide unit.
// The master side issues operations and moves; the slave side (the unit) returns HI/LO and status.
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] src_a_i;
    logic [WIDTH-1:0] src_b_i;
    logic             mthi_i;
    logic             mtlo_i;
    logic [WIDTH-1:0] wdata_i;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             busy_o;
    logic             stall_o;
    logic             done_o;
    logic             div_zero_o;

    modport master (
        output start_i, op_i, src_a_i, src_b_i, mthi_i, mtlo_i, wdata_i,
        input  hi_o, lo_o, busy_o, stall_o, done_o, div_zero_o
    );

    modport slave (
        input  start_i, op_i, src_a_i, src_b_i, mthi_i, mtlo_i, wdata_i,
        output hi_o, lo_o, busy_o, stall_o, done_o, div_zero_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, one bit per falling clock edge.
// Operands are processed as magnitudes; the sign correction is applied once in FIX.
module ex_muldiv #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 6
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    ex_muldiv_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [1:0]           r_op;
    logic                 r_sign_a;
    logic                 r_sign_b;
    logic                 r_div_zero;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [2*WIDTH-1:0]   r_acc;

    logic                 w_start_signed;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic                 w_is_div;
    logic                 w_is_signed;
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_trial;
    logic [2*WIDTH-1:0]   w_step_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_dz_hi;

    // op_i[0] = unsigned, op_i[1] = divide
    assign w_start_signed = ~bus.op_i[0];
    assign w_abs_a = (w_start_signed && bus.src_a_i[WIDTH-1]) ? -bus.src_a_i : bus.src_a_i;
    assign w_abs_b = (w_start_signed && bus.src_b_i[WIDTH-1]) ? -bus.src_b_i : bus.src_b_i;
    assign w_is_div    = r_op[1];
    assign w_is_signed = ~r_op[0];

    // NOTE: every variable gets a value on every path through always_comb, otherwise a latch is inferred.
    always_comb begin
        w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
        w_trial   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_b};
        if (!w_is_div) begin
            w_step_next = {w_mul_sum, r_acc[WIDTH-1:1]};
        end else if (w_trial[WIDTH]) begin
            w_step_next = {r_acc[2*WIDTH-2:0], 1'b0};
        end else begin
            w_step_next = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end
        w_prod  = (w_is_signed && (r_sign_a ^ r_sign_b)) ? -r_acc : r_acc;
        w_quot  = (w_is_signed && (r_sign_a ^ r_sign_b)) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem   = (w_is_signed && r_sign_a) ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_dz_hi = (w_is_signed && r_sign_a) ? -r_a : r_a;
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(negedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (bus.start_i) w_next_state = S_RUN;
            S_RUN:  if (r_cnt == LAST_STEP) w_next_state = S_FIX;
            S_FIX:  w_next_state = S_DONE;
            S_DONE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy_o     = (r_state != S_IDLE);
        bus.stall_o    = (bus.start_i && (r_state == S_IDLE)) || (r_state == S_RUN) || (r_state == S_FIX);
        bus.done_o     = (r_state == S_DONE);
        bus.div_zero_o = (r_state == S_DONE) && r_div_zero;
        bus.hi_o       = r_hi;
        bus.lo_o       = r_lo;
    end

    // NOTE: the operand and accumulator registers are reset too, so a reset leaves no stale operand behind.
    always_ff @(negedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_op       <= '0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_div_zero <= 1'b0;
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_op       <= bus.op_i;
                        r_sign_a   <= bus.src_a_i[WIDTH-1];
                        r_sign_b   <= bus.src_b_i[WIDTH-1];
                        r_div_zero <= bus.op_i[1] && (bus.src_b_i == '0);
                        r_cnt      <= '0;
                        r_a        <= w_abs_a;
                        r_b        <= w_abs_b;
                        r_acc      <= {{WIDTH{1'b0}}, (bus.op_i[1] ? w_abs_a : w_abs_b)};
                    end else begin
                        if (bus.mthi_i) r_hi <= bus.wdata_i;
                        if (bus.mtlo_i) r_lo <= bus.wdata_i;
                    end
                end
                S_RUN: begin
                    r_acc <= w_step_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    if (!w_is_div) begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end else if (r_div_zero) begin
                        r_hi <= w_dz_hi;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: an arithmetic reference model checked every cycle,
// plus directed operations with hand-computed HI/LO and latency expectations.
module tb_ex_muldiv;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    ex_muldiv_if #(.WIDTH(W)) bus();

    ex_muldiv #(.WIDTH(W), .CNT_WIDTH(6)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {div_zero, HI, LO} from plain integer arithmetic.
    function automatic logic [64:0] calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            2'b00: p = longint'(sa) * longint'(sb);
            2'b01: p = {32'h0, a} * {32'h0, b};
            2'b10: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'h0, 32'h8000_0000};
                else p = {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                p = {a % b, a / b};
            end
        endcase
        return {1'b0, p};
    endfunction

    // m_k counts edges since the accepted start (0 = idle); result lands at W+1, done shows at W+2.
    int          m_k;
    logic [31:0] m_hi, m_lo;
    logic [64:0] m_pend;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k    <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_pend <= '0;
        end else if (m_k == 0) begin
            if (bus.start_i) begin
                m_pend <= calc(bus.op_i, bus.src_a_i, bus.src_b_i);
                m_k    <= 1;
            end else begin
                if (bus.mthi_i) m_hi <= bus.wdata_i;
                if (bus.mtlo_i) m_lo <= bus.wdata_i;
            end
        end else if (m_k == W + 1) begin
            m_hi <= m_pend[63:32];
            m_lo <= m_pend[31:0];
            m_k  <= W + 2;
        end else if (m_k == W + 2) begin
            m_k <= 0;
        end else begin
            m_k <= m_k + 1;
        end
    end

    always begin
        @(posedge clk);
        #2;
        if (chk_en) begin
            check("cyc_hi", bus.hi_o, m_hi);
            check("cyc_lo", bus.lo_o, m_lo);
            check("cyc_busy", bus.busy_o, m_k != 0);
            check("cyc_stall", bus.stall_o, (m_k == 0 && bus.start_i) || (m_k >= 1 && m_k <= W + 1));
            check("cyc_done", bus.done_o, m_k == W + 2);
            check("cyc_dz", bus.div_zero_o, (m_k == W + 2) && m_pend[64]);
        end
    end

    task automatic idle_inputs();
        bus.start_i = 1'b0;
        bus.op_i    = 2'b00;
        bus.src_a_i = '0;
        bus.src_b_i = '0;
        bus.mthi_i  = 1'b0;
        bus.mtlo_i  = 1'b0;
        bus.wdata_i = '0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit with_move);
        @(posedge clk);
        #1;
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.src_a_i = a;
        bus.src_b_i = b;
        if (with_move) begin
            bus.mthi_i  = 1'b1;
            bus.mtlo_i  = 1'b1;
            bus.wdata_i = 32'hCAFE_F00D;
        end
        #1;
        check("stall_start", bus.stall_o, 1);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dz,
                          input bit disturb, input bit with_move);
        int k;
        bit seen;
        issue(op, a, b, with_move);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 80) begin
            @(posedge clk);
            #3;
            k++;
            if (disturb && k == 5) begin
                bus.start_i = 1'b1;
                bus.op_i    = ~op;
                bus.mthi_i  = 1'b1;
                bus.mtlo_i  = 1'b1;
                bus.wdata_i = 32'hDEAD_BEEF;
            end else begin
                idle_inputs();
            end
            if (bus.done_o) seen = 1'b1;
        end
        check({name, "_done_seen"}, seen, 1);
        check({name, "_latency"}, k, W + 1);
        check({name, "_hi"}, bus.hi_o, exp_hi);
        check({name, "_lo"}, bus.lo_o, exp_lo);
        check({name, "_dz"}, bus.div_zero_o, exp_dz);
        check({name, "_stall_done"}, bus.stall_o, 0);
        @(posedge clk);
        #3;
        check({name, "_done_pulse"}, bus.done_o, 0);
        check({name, "_idle"}, bus.busy_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        #1;
        bus.start_i = 1'b1;
        #1;
        check("rst_hi", bus.hi_o, 0);
        check("rst_lo", bus.lo_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_stall_follows_start", bus.stall_o, 1);
        bus.start_i = 1'b0;
        #1;
        check("rst_stall_low", bus.stall_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        run_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0, 1'b0);
        run_op("mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
        run_op("div_7dm2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
        run_op("divu_max7", 2'b11, 32'hFFFF_FFFF, 32'd7, 32'h0000_0003, 32'h2492_4924, 1'b0, 1'b0, 1'b0);
        run_op("divu_by0", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op("div_m5by0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        run_op("multu_disturb", 2'b01, 32'h0000_1234, 32'h0000_0010, 32'h0000_0000, 32'h0001_2340, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of RUN, then a fresh operation.
        run_op("mult_seed", 2'b00, 32'hFFFF_FFFF, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b0, 1'b0, 1'b0);
        issue(2'b01, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
        repeat (10) @(posedge clk);
        #3;
        check("midrun_busy", bus.busy_o, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_hi", bus.hi_o, 0);
        check("midrst_lo", bus.lo_o, 0);
        check("midrst_busy", bus.busy_o, 0);
        check("midrst_stall", bus.stall_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op("multu_6x7", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0, 1'b0);

        // Register moves while idle, then a start that drops a simultaneous move.
        @(posedge clk);
        #1;
        bus.mthi_i  = 1'b1;
        bus.mtlo_i  = 1'b1;
        bus.wdata_i = 32'h1234_5678;
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("move_hi", bus.hi_o, 32'h1234_5678);
        check("move_lo", bus.lo_o, 32'h1234_5678);
        @(posedge clk);
        #1;
        bus.mthi_i  = 1'b1;
        bus.wdata_i = 32'h0000_1111;
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("mthi_only_hi", bus.hi_o, 32'h0000_1111);
        check("mthi_only_lo", bus.lo_o, 32'h1234_5678);
        run_op("start_beats_move", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0, 1'b1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter: WIDTH, 32, operand/HI/LO data width.
REQ-002 Parameter: CNT_WIDTH, 6, iteration counter width; must hold the value WIDTH.
REQ-003 Port: clk_i  input  1  single clock; all state updates on the falling edge, matching the ID/EX pipeline registers.
REQ-004 Port: rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 Port: start_i  input  1  mul/div request from the ID/EX EX control field.
REQ-006 Port: op_i  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 Port: src_a_i  input  WIDTH  multiplicand or dividend (ID/EX data1).
REQ-008 Port: src_b_i  input  WIDTH  multiplier or divisor (ID/EX data2).
REQ-009 Port: mthi_i  input  1  write wdata_i to HI.
REQ-010 Port: mtlo_i  input  1  write wdata_i to LO.
REQ-011 Port: wdata_i  input  WIDTH  MTHI/MTLO data.
REQ-012 Port: hi_o  output  WIDTH  HI register (MFHI source).
REQ-013 Port: lo_o  output  WIDTH  LO register (MFLO source).
REQ-014 Port: busy_o  output  1  FSM is not in IDLE.
REQ-015 Port: stall_o  output  1  combinational; drives keep_d of the IF/ID and ID/EX registers.
REQ-016 Port: done_o  output  1  one-cycle pulse when HI/LO take a result.
REQ-017 Port: div_zero_o  output  1  one-cycle pulse, coincident with done_o, for a divide by zero.

Function
REQ-018 FSM states: IDLE, RUN, FIX, DONE; encoding is free.
REQ-019 IDLE with start_i=1 at an edge: latch op_i, abs(src_a_i) and abs(src_b_i) for signed ops (raw values for unsigned ops), and both operand sign bits; clear counter; go to RUN.
REQ-020 RUN: one shift-add step (mul) or restoring subtract-shift step (div) per edge; after exactly WIDTH steps go to FIX.
REQ-021 FIX, one edge: apply signed correction; write HI/LO; go to DONE.
REQ-022 DONE: done_o=1 for one cycle; next edge goes to IDLE.
REQ-023 Latency: start sampled at edge N; HI/LO updated at edge N+WIDTH+1; done_o high from that edge until edge N+WIDTH+2.
REQ-024 MULT/MULTU: {HI,LO} = full 2*WIDTH-bit product; signed product is negated when operand signs differ.
REQ-025 DIV/DIVU: LO = quotient, HI = remainder; signed quotient is negated when signs differ; signed remainder takes the dividend's sign.
REQ-026 Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0; no flag.
REQ-027 Divisor zero, any div op: full latency still applies; LO = all ones; HI = src_a_i as latched; div_zero_o pulses with done_o.
REQ-028 stall_o = (start_i AND IDLE) OR RUN OR FIX; it is 0 in DONE, so the stalled MFHI/MFLO issues in the done_o cycle.
REQ-029 start_i outside IDLE: ignored.
REQ-030 mthi_i/mtlo_i in IDLE: write wdata_i at that edge; both may be asserted in the same cycle.
REQ-031 mthi_i/mtlo_i outside IDLE: ignored.
REQ-032 start_i together with mthi_i/mtlo_i in IDLE: start wins; the move is dropped.
REQ-033 HI/LO change only in FIX and on an accepted move; they hold across all other cycles and across stalls.

Reset
REQ-034 rst_n_i low, asynchronously and at any state including mid-RUN: state=IDLE, counter=0, HI=LO=0, busy_o=0, done_o=0, div_zero_o=0, internal operands=0; stall_o=start_i.
REQ-035 After rst_n_i rises, the first accepted start_i behaves exactly per REQ-019.

Verification
REQ-036 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done_o exactly WIDTH+1 edges after start.
REQ-037 MULT -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-038 DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100, div_zero_o=1 in the done cycle; DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
REQ-039 stall_o high from the start cycle through FIX and low in DONE; start_i and mthi_i pulsed mid-RUN -> no effect on HI/LO or timing.
REQ-040 rst_n_i pulsed low at RUN step 10 -> HI=LO=0, busy_o=0 immediately; new MULTU 6 x 7 -> LO=42, HI=0.
REQ-041 IDLE: mthi_i=mtlo_i=1, wdata_i=0x12345678 -> HI=LO=0x12345678 next edge; same cycle with start_i=1 -> move dropped, mul result written.
